risc_regfile_mp: RTL and testbench

- Parametrised successor register file for the risc core: DEPTH = 2**ADDR_W entries of DATA_W bits, NREAD independent registered read ports and one write port.
- Adds write-first bypass, optional hardwired-zero register 0, and a hardware clear sequencer that zeroes the array after reset or on request.
- Sits between decode (read addresses) and writeback (rd); stalls the pipeline via init_busy while clearing.

---
 rtl/risc_pkg.sv | 13 +
 rtl/risc_regfile_rport.sv | 41 ++++
 rtl/risc_regfile_mp.sv | 106 ++++++++++
 tb/tb_risc_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared constants and types for the risc register file family.
package risc_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 4;

  // INIT walks the array writing zeros; RUN serves normal reads and writes.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/risc_regfile_rport.sv
// One registered read port: selects array data, forwarded write data or zero.
module risc_regfile_rport
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data
);

  logic [DATA_W-1:0] data_d, data_q;

  // Zero forcing wins over forwarding so register 0 stays zero even on a hit.
  always_comb begin
    data_d = mem_data;
    if (!run || (ZERO_R0 && rs_addr == '0)) begin
      data_d = '0;
    end else if (BYPASS && wr_en && wr_addr == rs_addr) begin
      data_d = wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign rs_data = data_q;

endmodule

// File: rtl/risc_regfile_mp.sv
// Multi-port register file with write-first bypass, optional zero r0 and a clear sequencer.
module risc_regfile_mp
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NREAD   = 2,
  parameter bit          ZERO_R0 = 1'b0,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREAD*ADDR_W-1:0] rs_addr,
  output logic [NREAD*DATA_W-1:0] rs_data,
  input  logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_write,
  input  logic [DATA_W-1:0]       rd,
  input  logic                    clear,
  output logic                    init_busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                init_busy_q, init_busy_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                wr_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // NOTE: every signal driven here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_en     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = rd_addr;
    mem_wdata = rd;
    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        if (clear) begin
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d   = ST_INIT;
          clr_cnt_d = '0;
        end else begin
          wr_en  = rd_write && !(ZERO_R0 && rd_addr == '0);
          mem_we = wr_en;
        end
      end
      default: state_d = ST_INIT;
    endcase
    init_busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
    end
  end

  // NOTE: the array has no reset branch; the INIT sequencer zeroes it instead.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign init_busy = init_busy_q;

  for (genvar i = 0; i < NREAD; i++) begin : g_rport
    risc_regfile_rport #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
    ) u_rport (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (state_q == ST_RUN),
      .rs_addr  (rs_addr[i*ADDR_W +: ADDR_W]),
      .mem_data (mem_q[rs_addr[i*ADDR_W +: ADDR_W]]),
      .wr_en    (wr_en),
      .wr_addr  (rd_addr),
      .wr_data  (rd),
      .rs_data  (rs_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_risc_regfile_mp.sv
// Drives three register-file variants (default, read-first, zero-r0) against an array model.
module tb_risc_regfile_mp;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rs_addr;
  logic [3:0]  rd_addr;
  logic        rd_write;
  logic [7:0]  rd;
  logic        clear;
  logic [15:0] rs_data [3];
  logic        busy    [3];

  always #5 clk = ~clk;

  risc_regfile_mp u_dut_def (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data[0]), .rd_addr(rd_addr),
    .rd_write(rd_write), .rd(rd), .clear(clear), .init_busy(busy[0]));

  risc_regfile_mp #(.BYPASS(1'b0)) u_dut_rf (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data[1]), .rd_addr(rd_addr),
    .rd_write(rd_write), .rd(rd), .clear(clear), .init_busy(busy[1]));

  risc_regfile_mp #(.ZERO_R0(1'b1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data[2]), .rd_addr(rd_addr),
    .rd_write(rd_write), .rd(rd), .clear(clear), .init_busy(busy[2]));

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  mdl [3][DEPTH];
  logic [15:0] exp_rs [3];
  int          busy_left;

  function automatic bit byp(int k);
    return k != 1;
  endfunction

  function automatic bit zr(int k);
    return k == 2;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: update the behavioural model from the sampled inputs, then compare all DUTs.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      busy_left = DEPTH;
      for (int k = 0; k < 3; k++) exp_rs[k] = '0;
    end else if (busy_left > 0) begin
      for (int k = 0; k < 3; k++) begin
        mdl[k][DEPTH - busy_left] = '0;
        exp_rs[k] = '0;
      end
      busy_left = clear ? DEPTH : busy_left - 1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        bit wv;
        wv = rd_write && !clear && !(zr(k) && rd_addr == 4'd0);
        for (int p = 0; p < 2; p++) begin
          logic [3:0] a;
          logic [7:0] v;
          a = rs_addr[p*4 +: 4];
          v = mdl[k][a];
          if (zr(k) && a == 4'd0) v = '0;
          else if (byp(k) && wv && rd_addr == a) v = rd;
          exp_rs[k][p*8 +: 8] = v;
        end
        if (wv) mdl[k][rd_addr] = rd;
      end
      if (clear) busy_left = DEPTH;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy_dut%0d", k), {15'd0, busy[k]}, {15'd0, busy_left > 0});
      check($sformatf("rs_data_dut%0d", k), rs_data[k], exp_rs[k]);
    end
  endtask

  task automatic idle();
    rd_write = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    rd_write = 1'b1;
    rd_addr  = a;
    rd       = d;
  endtask

  // Counts cycles until init_busy drops on the default DUT, bounded at 40.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy[0] && n < 40);
    check(tag, 16'(n), 16'(DEPTH));
  endtask

  initial begin
    rst_n = 1'b0; rs_addr = '0; rd_addr = '0; rd = '0;
    idle();
    busy_left = DEPTH;
    tick();
    tick();
    rst_n = 1'b1;
    count_busy("init_len_after_reset");

    for (int a = 0; a < DEPTH; a++) begin
      rs_addr = {4'(a), 4'(a)};
      tick();
    end

    write(4'd3, 8'hA5); tick();
    write(4'd7, 8'h3C); tick();
    idle(); rs_addr = {4'd7, 4'd3}; tick();
    check("wr_rd_pair", rs_data[0], 16'h3CA5);

    write(4'd5, 8'h11); tick();
    write(4'd5, 8'h22); rs_addr = {4'd5, 4'd5}; tick();
    check("hazard_bypass", rs_data[0], 16'h2222);
    check("hazard_readfirst", rs_data[1], 16'h1111);
    idle(); tick();
    check("hazard_readfirst_next", rs_data[1], 16'h2222);

    write(4'd0, 8'hFF); tick();
    idle(); rs_addr = 8'h00; tick();
    check("zero_r0_read", rs_data[2], 16'h0000);
    write(4'd0, 8'hFF); tick();
    check("zero_r0_bypass", rs_data[2], 16'h0000);
    check("r0_normal_bypass", rs_data[0], 16'hFFFF);

    for (int a = 0; a < DEPTH; a++) begin
      write(4'(a), 8'h80 + 8'(a));
      tick();
    end
    idle();
    write(4'd2, 8'h55); clear = 1'b1; rs_addr = {4'd2, 4'd2};
    tick();
    clear = 1'b0;
    count_busy("init_len_after_clear");
    idle();
    tick();
    check("r2_cleared", rs_data[0], 16'h0000);
    for (int a = 0; a < DEPTH; a++) begin
      rs_addr = {4'(a), 4'(DEPTH - 1 - a)};
      tick();
    end

    clear = 1'b1; tick();
    clear = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    count_busy("init_len_after_mid_reset");

    for (int i = 0; i < 600; i++) begin
      rs_addr  = 8'($urandom);
      rd_addr  = 4'($urandom);
      rd       = 8'($urandom);
      rd_write = ($urandom_range(0, 3) != 0);
      clear    = ($urandom_range(0, 79) == 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) rs_addr[3:0] = rd_addr;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
